map_redraw_engine: RTL

Responder to the game-state controller's redraw handshake. When `drawMap` is asserted it latches `gameState`, selects the matching background image and rasters every pixel of the 320x240 screen to the VGA adapter. It then raises `doneRedraw` and holds it until the controller withdraws `drawMap`. It sits between the game-state controller, the background image ROMs and the VGA adapter's plot port.

---
 rtl/map_redraw_if.sv | 28 ++
 rtl/map_redraw_engine.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/map_redraw_if.sv
// Redraw handshake, image ROM read port and VGA plot port of the map redraw
// engine, bundled into one interface.
//   slave  : the redraw engine itself
//   master : the surrounding system (game-state controller, image ROM, VGA)
interface map_redraw_if #(
  parameter int COLOUR_W = 9
);
  logic                drawMap;
  logic [3:0]          gameState;
  logic [COLOUR_W-1:0] rom_data;
  logic [2:0]          rom_sel;
  logic [16:0]         rom_addr;
  logic                plot;
  logic [8:0]          x;
  logic [7:0]          y;
  logic [COLOUR_W-1:0] colour;
  logic                doneRedraw;

  modport slave (
    input  drawMap, gameState, rom_data,
    output rom_sel, rom_addr, plot, x, y, colour, doneRedraw
  );

  modport master (
    output drawMap, gameState, rom_data,
    input  rom_sel, rom_addr, plot, x, y, colour, doneRedraw
  );
endinterface

// File: rtl/map_redraw_engine.sv
// Map redraw engine: on a drawMap request, latches gameState, picks the
// matching background image and rasters every pixel of the screen from the
// image ROM to the VGA plot port, then holds doneRedraw until drawMap drops.
// Optional feature: define MAP_REDRAW_TRANSPARENT_EN to suppress the plot
// strobe for pixels whose ROM colour equals TRANSPARENT.
module map_redraw_engine #(
  parameter int                  WIDTH       = 320,
  parameter int                  HEIGHT      = 240,
  parameter int                  COLOUR_W    = 9,
  parameter logic [COLOUR_W-1:0] TRANSPARENT = {COLOUR_W{1'b1}}
) (
  input  logic         clock,
  input  logic         resetn,
  map_redraw_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_t;

  state_t      state, state_next;
  logic        start;        // latch gameState and clear the raster counters
  logic        issue;        // issue the address of pixel (cx, cy) this cycle
  logic        last_pix;
  logic [8:0]  cx;
  logic [7:0]  cy;
  logic [3:0]  sel_state;
  logic [16:0] addr_next;
  logic [8:0]  issue_x;      // coordinates travelling alongside the ROM read
  logic [7:0]  issue_y;
  logic        issue_valid;
  logic        plot_slot;    // a pixel's ROM data is on rom_data this cycle
  logic        skip;

  // Image number for each controller state code.
  function automatic logic [2:0] image_select(input logic [3:0] code);
    case (code)
      4'd1, 4'd2: return 3'd1;
      4'd3, 4'd4: return 3'd2;
      4'd5, 4'd6: return 3'd3;
      4'd7, 4'd8: return 3'd4;
      4'd9:       return 3'd5;
      default:    return 3'd0;
    endcase
  endfunction

  assign last_pix  = (cx == 9'(WIDTH - 1)) && (cy == 8'(HEIGHT - 1));
  assign addr_next = 17'(cy) * 17'(WIDTH) + 17'(cx);

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state and control decode.
  always_comb begin
    // NOTE: defaults first, so no path through this block leaves a signal
    // unassigned and infers a latch.
    state_next = state;
    start      = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.drawMap) begin
          start      = 1'b1;
          state_next = DRAW;
        end
      end
      DRAW: begin
        if (!bus.drawMap) begin
          state_next = IDLE;
        end else begin
          issue = 1'b1;
          if (last_pix) state_next = FLUSH;
        end
      end
      FLUSH: state_next = bus.drawMap ? DONE : IDLE;
      DONE: begin
        if (!bus.drawMap) begin
          state_next = IDLE;
        end else if (bus.gameState != sel_state) begin
          start      = 1'b1;
          state_next = DRAW;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Raster counters, ROM address issue and the one-stage plot pipeline.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cx             <= '0;
      cy             <= '0;
      sel_state      <= '0;
      bus.rom_sel    <= '0;
      bus.rom_addr   <= '0;
      issue_x        <= '0;
      issue_y        <= '0;
      issue_valid    <= 1'b0;
      plot_slot      <= 1'b0;
      bus.x          <= '0;
      bus.y          <= '0;
      bus.doneRedraw <= 1'b0;
    end else begin
      if (start) begin
        sel_state <= bus.gameState;
        cx        <= '0;
        cy        <= '0;
      end else if (issue) begin
        if (cx == 9'(WIDTH - 1)) begin
          cx <= '0;
          cy <= cy + 8'd1;
        end else begin
          cx <= cx + 9'd1;
        end
      end
      bus.rom_sel <= image_select(sel_state);
      issue_valid <= issue;
      if (issue) begin
        bus.rom_addr <= addr_next;
        issue_x      <= cx;
        issue_y      <= cy;
      end
      plot_slot      <= issue_valid;
      bus.x          <= issue_x;
      bus.y          <= issue_y;
      bus.doneRedraw <= (state == DONE) && (state_next == DONE);
    end
  end

`ifdef MAP_REDRAW_TRANSPARENT_EN
  assign skip = (bus.rom_data == TRANSPARENT);
`else
  assign skip = 1'b0;
`endif

  // The ROM's registered output arrives in the same cycle as the pixel's
  // x/y, so colour and the strobe are gated from it directly.
  assign bus.plot   = plot_slot & ~skip;
  assign bus.colour = plot_slot ? bus.rom_data : '0;

endmodule
